// File: rtl/wish_blinky_multi.sv
// Multi-channel LED pattern blinker behind a Wishbone-subset slave port.
// Each channel shifts its pattern on a shared prescaler tick and drives an active-low LED.
module wish_blinky_multi #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned MASK_BITS = 8,
    parameter int unsigned DIV_BITS  = 22,
    parameter int unsigned DAT_W     = 8,
    parameter int unsigned ADR_BITS  = 4
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic                STB_I,
    input  logic                WE_I,
    input  logic [ADR_BITS-1:0] ADR_I,
    input  logic [DAT_W-1:0]    DAT_I,
    output logic [DAT_W-1:0]    DAT_O,
    output logic                ACK_O,
    output logic [NUM_CH-1:0]   oN_led
);

    localparam int unsigned IDX_W = ADR_BITS - 1;

    logic [DIV_BITS-1:0]  div_q;
    logic                 tick_c;
    logic [MASK_BITS-1:0] mask_q [NUM_CH];
    logic [MASK_BITS-1:0] mask_d [NUM_CH];
    logic [NUM_CH-1:0]    en_q, en_d;
    logic [NUM_CH-1:0]    mode_q, mode_d;
    logic [NUM_CH-1:0]    done_q, done_d;
    logic                 acc_c, wr_c, ctl_c;
    logic [IDX_W-1:0]     idx_c;
    logic [DAT_W-1:0]     rd_c;

    // A new access is taken only when no acknowledge is pending, giving one access per two cycles.
    assign acc_c  = STB_I & ~ACK_O;
    assign wr_c   = acc_c & WE_I;
    assign ctl_c  = ADR_I[ADR_BITS-1];
    assign idx_c  = ADR_I[ADR_BITS-2:0];
    assign tick_c = &div_q;

    // Read mux; unmapped addresses return zero.
    always_comb begin
        rd_c = '0;
        if (ctl_c) begin
            if (idx_c == IDX_W'(0))
                rd_c = DAT_W'(en_q);
            else if (idx_c == IDX_W'(1))
                rd_c = DAT_W'(mode_q);
            else if (idx_c == IDX_W'(2))
                rd_c = DAT_W'(done_q);
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (idx_c == IDX_W'(c))
                    rd_c = DAT_W'(mask_q[c]);
            end
        end
    end

    // Register writes and per-channel shifting; a mask write overrides a same-cycle tick.
    always_comb begin
        en_d   = en_q;
        mode_d = mode_q;
        done_d = done_q;
        for (int c = 0; c < NUM_CH; c++)
            mask_d[c] = mask_q[c];

        if (wr_c && ctl_c) begin
            if (idx_c == IDX_W'(0))
                en_d = DAT_I[NUM_CH-1:0];
            else if (idx_c == IDX_W'(1))
                mode_d = DAT_I[NUM_CH-1:0];
            else if (idx_c == IDX_W'(2))
                done_d = done_q & ~DAT_I[NUM_CH-1:0];
        end

        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_c && !ctl_c && (idx_c == IDX_W'(c))) begin
                mask_d[c] = DAT_I[MASK_BITS-1:0];
                done_d[c] = 1'b0;
            end else if (tick_c && en_q[c] && (mask_q[c] != '0)) begin
                if (mode_q[c]) begin
                    mask_d[c] = {mask_q[c][MASK_BITS-2:0], 1'b0};
                    if (mask_q[c][MASK_BITS-2:0] == '0)
                        done_d[c] = 1'b1;
                end else begin
                    mask_d[c] = {mask_q[c][MASK_BITS-2:0], mask_q[c][MASK_BITS-1]};
                end
            end
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            div_q  <= '0;
            en_q   <= '0;
            mode_q <= '0;
            done_q <= '0;
            DAT_O  <= '0;
            ACK_O  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++)
                mask_q[c] <= '0;
        end else begin
            div_q  <= div_q + DIV_BITS'(1);
            en_q   <= en_d;
            mode_q <= mode_d;
            done_q <= done_d;
            ACK_O  <= acc_c;
            if (acc_c && !WE_I)
                DAT_O <= rd_c;
            for (int c = 0; c < NUM_CH; c++)
                mask_q[c] <= mask_d[c];
        end
    end

    // LEDs are active-low and follow each pattern's MSB.
    always_comb begin
        oN_led = '1;
        for (int c = 0; c < NUM_CH; c++)
            oN_led[c] = ~mask_q[c][MASK_BITS-1];
    end

endmodule

// File: doc/wish_blinky_multi.md
Name: wish_blinky_multi

Overview:
Multi-channel, parametrised pattern blinker with a Wishbone-subset slave port.
- Each of NUM_CH channels holds a MASK_BITS-wide pattern register. The register shifts once per shared prescaler tick and drives one active-low LED from its MSB.
- Channels run in free-running rotate mode or one-shot mode and can be enabled individually.
- Sits behind the bus master as the LED/status peripheral.

Parameters:
- NUM_CH, 4, number of LED channels (1..8).
- MASK_BITS, 8, pattern width per channel (>=2).
- DIV_BITS, 22, prescaler width; tick period = 2^DIV_BITS CLK_I cycles.
- DAT_W, 8, bus data width; must be >= MASK_BITS and >= NUM_CH.
- ADR_BITS, 4, address width; must satisfy 2^(ADR_BITS-1) >= NUM_CH and ADR_BITS >= 3.

Ports:
- CLK_I  in  1  system clock; all state on rising edge.
- RST_I  in  1  asynchronous, active-high reset.
- STB_I  in  1  access strobe.
- WE_I  in  1  1 = write, 0 = read.
- ADR_I  in  ADR_BITS  register address.
- DAT_I  in  DAT_W  write data.
- DAT_O  out  DAT_W  registered read data.
- ACK_O  out  1  access acknowledge.
- oN_led  out  NUM_CH  active-low LEDs; bit c = ~mask[c][MASK_BITS-1].

Behaviour:
Reset (async, while RST_I=1):
- All masks = 0, enable = 0, mode = 0, done = 0, prescaler = 0, DAT_O = 0, ACK_O = 0.
- Therefore oN_led = all ones (all LEDs off).
- Reset mid-access aborts the access; no ACK is produced.

Address map:
- ADR_I[ADR_BITS-1] = 0: mask register of channel ADR_I[ADR_BITS-2:0]. Channel index >= NUM_CH is unmapped.
- ADR_I[ADR_BITS-1] = 1, low bits 0: ENABLE[NUM_CH-1:0], R/W.
- ADR_I[ADR_BITS-1] = 1, low bits 1: MODE[NUM_CH-1:0], R/W; 0 = rotate, 1 = one-shot.
- ADR_I[ADR_BITS-1] = 1, low bits 2: DONE[NUM_CH-1:0]; read-only, write-1-to-clear.
- All other addresses are unmapped: writes ignored, reads return 0, still ACKed.
- Narrow fields use DAT_I LSBs; unused DAT_O bits read 0.

Handshake:
- An access is accepted in a cycle where STB_I=1 and ACK_O=0.
- Write data and read data (DAT_O) are registered on that edge.
- ACK_O = 1 for exactly the following cycle, then 0. Latency is 1 cycle.
- If STB_I stays high, accesses occur every 2nd cycle.
- DAT_O holds its value until the next read.

Prescaler:
- DIV_BITS counter, free-running out of reset.
- tick = one-cycle pulse when the counter is all ones; the counter then wraps to 0.
- First tick occurs 2^DIV_BITS cycles after reset release.
- Writes do not affect the prescaler.

Per-channel update on tick, when ENABLE[c]=1 and mask[c] != 0:
- Rotate mode: mask <= {mask[MASK_BITS-2:0], mask[MASK_BITS-1]}.
- One-shot mode: mask <= {mask[MASK_BITS-2:0], 1'b0}. If the result is 0, set DONE[c].
- ENABLE[c]=0: mask holds.

Precedence and boundary cases:
- Mask write coinciding with a tick for the same channel: the write wins, no shift that tick.
- A mask write clears DONE[c].
- ENABLE/MODE write coinciding with a tick: the tick uses the pre-write register values.
- DONE set by a tick and W1C for the same bit in the same cycle: set wins.
- mask = 0 never sets DONE again; the channel stays idle.
- Changing MODE mid-pattern takes effect from the next tick; the mask is unchanged.

Test Plan:
Bench parameters: NUM_CH=2, MASK_BITS=8, DIV_BITS=3, DAT_W=8, ADR_BITS=3 (tick every 8 cycles).
1. Reset: assert RST_I asynchronously mid-cycle -> oN_led=2'b11, ACK_O=0 immediately; all registers read 0 after release.
2. Rotate: write mask0=8'hA5, ENABLE=1 -> mask0 = 4B, 96, 2D on successive ticks and 5A after the 4th; oN_led[0] = ~MSB at each step; channel 1 unchanged.
3. One-shot: write mask1=8'hC0, MODE=2, ENABLE=2 -> mask1 = 80 then 00; DONE reads 2 after the 2nd tick; later ticks leave mask1 at 0; W1C 2 -> DONE reads 0.
4. Handshake: hold STB_I=1 with reads of ADR 0,1,4 -> ACK_O toggles 1/0; DAT_O = mask0, mask1, ENABLE, each valid in its ACK cycle; read of ADR 7 returns 0 with ACK.
5. Collision: time a mask0=8'h81 write to the tick cycle -> the following read returns 81 (no shift); the next tick gives 03.
6. Disable: clear ENABLE while rotating -> mask frozen across 3 ticks; re-enable -> resumes from the frozen value.
